// File: rtl/pdp6_iob.sv
// Shared PDP-6 IO bus definitions: PDP-6 bit positions (bit 0 is the MSB)
// and the paper-tape-punch state encoding.
package pdp6_iob;

  localparam int BIT_BINARY  = 30;
  localparam int BIT_BUSY    = 31;
  localparam int BIT_DONE    = 32;
  localparam int BIT_PIA_HI  = 33;
  localparam int BIT_PIA_LO  = 35;
  localparam int BIT_DATA_HI = 28;
  localparam int BIT_DATA_LO = 35;

  typedef enum logic [1:0] {
    PTP_IDLE,
    PTP_WAIT,
    PTP_PUNCH
  } ptp_state_e;

endpackage

// File: rtl/pia_dec.sv
// Priority-interrupt channel decoder: raises one of the seven PI request
// lines when a device is done and has a nonzero channel assignment.
module pia_dec (
  input  logic [2:0] pia_i,
  input  logic       req_i,
  output logic [1:7] pi_o
);

  always_comb begin
    pi_o = '0;
    for (int i = 1; i <= 7; i++) begin
      pi_o[i] = req_i && (pia_i == 3'(i));
    end
  end

endmodule

// File: rtl/ptp.sv
// PDP-6 paper tape punch: CONO/DATAO/CONI device on the IO bus that punches
// one frame per DATAO and hands it to a host sink over valid/ready.
module ptp
  import pdp6_iob::*;
#(
  parameter logic [6:0]  DEVNO     = 7'o020,
  parameter logic [15:0] PUNCH_CYC = 16'd100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iobus_iob_reset,
  input  logic [3:9]  iobus_ios,
  input  logic        iobus_cono_clear,
  input  logic        iobus_cono_set,
  input  logic        iobus_datao_clear,
  input  logic        iobus_datao_set,
  input  logic        iobus_iob_fm_status,
  input  logic [0:35] iobus_iob_in,
  output logic [0:35] iobus_iob_out,
  output logic [1:7]  iobus_pi_req,
  input  logic        sw_feed,
  output logic        frame_valid,
  output logic [7:0]  frame,
  input  logic        frame_ready
);

  ptp_state_e  state_q, state_d;
  logic [2:0]  pia_q, pia_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        binary_q, binary_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic        feed_q, feed_d;
  logic [7:0]  frame_q, frame_d;
  logic        valid_q, valid_d;
  logic        sel;
  logic        datao;
  logic        unusedBusBits;

  assign sel           = (iobus_ios == DEVNO);
  assign datao         = sel && (iobus_datao_clear || iobus_datao_set);
  assign unusedBusBits = ^iobus_iob_in[0:27] ^ iobus_iob_in[29];

  // The frame is captured from the buffer as updated this cycle, so a late
  // DATAO in WAIT still lands; flag updates apply handshake, then CONO, then DATAO.
  always_comb begin
    state_d  = state_q;
    pia_d    = pia_q;
    done_d   = done_q;
    busy_d   = busy_q;
    binary_d = binary_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    feed_d   = feed_q;
    frame_d  = frame_q;
    valid_d  = valid_q;

    if (sel && iobus_datao_clear) data_d = '0;
    if (sel && iobus_datao_set)   data_d = data_d | iobus_iob_in[BIT_DATA_HI:BIT_DATA_LO];

    case (state_q)
      PTP_IDLE: begin
        if (datao) begin
          state_d = PTP_WAIT;
          cnt_d   = PUNCH_CYC - 16'd1;
          feed_d  = 1'b0;
        end else if (sw_feed && !busy_q) begin
          state_d = PTP_WAIT;
          cnt_d   = PUNCH_CYC - 16'd1;
          feed_d  = 1'b1;
        end
      end
      PTP_WAIT: begin
        if (cnt_q == 16'd0) begin
          state_d = PTP_PUNCH;
          valid_d = 1'b1;
          if (feed_q)        frame_d = 8'h00;
          else if (binary_q) frame_d = {2'b10, data_d[5:0]};
          else               frame_d = data_d;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      PTP_PUNCH: begin
        if (frame_ready) begin
          state_d = PTP_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          if (!feed_q) done_d = 1'b1;
        end
      end
      default: state_d = PTP_IDLE;
    endcase

    if (sel && iobus_cono_clear) begin
      pia_d    = '0;
      done_d   = 1'b0;
      busy_d   = 1'b0;
      binary_d = 1'b0;
    end
    if (sel && iobus_cono_set) begin
      binary_d = binary_d | iobus_iob_in[BIT_BINARY];
      busy_d   = busy_d   | iobus_iob_in[BIT_BUSY];
      done_d   = done_d   | iobus_iob_in[BIT_DONE];
      pia_d    = pia_d    | iobus_iob_in[BIT_PIA_HI:BIT_PIA_LO];
    end
    if (datao) begin
      done_d = 1'b0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || iobus_iob_reset) begin
      state_q  <= PTP_IDLE;
      pia_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      binary_q <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
      feed_q   <= 1'b0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pia_q    <= pia_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      binary_q <= binary_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      feed_q   <= feed_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    iobus_iob_out = '0;
    if (iobus_iob_fm_status && sel) begin
      iobus_iob_out[BIT_BINARY]             = binary_q;
      iobus_iob_out[BIT_BUSY]               = busy_q;
      iobus_iob_out[BIT_DONE]               = done_q;
      iobus_iob_out[BIT_PIA_HI:BIT_PIA_LO]  = pia_q;
    end
  end

  pia_dec u_pia_dec (
    .pia_i (pia_q),
    .req_i (done_q),
    .pi_o  (iobus_pi_req)
  );

  assign frame_valid = valid_q;
  assign frame       = frame_q;

endmodule

// File: tb/tb_ptp.sv
// Self-checking bench for the paper tape punch: directed bus sequences plus
// randomized punches compared against a flag/frame model kept in the bench.
module tb_ptp;

  localparam logic [6:0]  DEVNO     = 7'o020;
  localparam logic [15:0] PUNCH_CYC = 16'd12;
  localparam int          PC        = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        iobReset = 1'b0;
  logic [3:9]  ios = DEVNO;
  logic        conoClear = 1'b0;
  logic        conoSet = 1'b0;
  logic        dataoClear = 1'b0;
  logic        dataoSet = 1'b0;
  logic        fmStatus = 1'b0;
  logic [0:35] iobIn = '0;
  logic [0:35] iobOut;
  logic [1:7]  piReq;
  logic        swFeed = 1'b0;
  logic        frameValid;
  logic [7:0]  frameOut;
  logic        frameReady = 1'b0;

  int checksTotal  = 0;
  int checksPassed = 0;

  logic [2:0] mPia = '0;
  logic       mDone = 1'b0;
  logic       mBusy = 1'b0;
  logic       mBinary = 1'b0;

  ptp #(.DEVNO(DEVNO), .PUNCH_CYC(PUNCH_CYC)) dut (
    .clk                 (clk),
    .reset               (reset),
    .iobus_iob_reset     (iobReset),
    .iobus_ios           (ios),
    .iobus_cono_clear    (conoClear),
    .iobus_cono_set      (conoSet),
    .iobus_datao_clear   (dataoClear),
    .iobus_datao_set     (dataoSet),
    .iobus_iob_fm_status (fmStatus),
    .iobus_iob_in        (iobIn),
    .iobus_iob_out       (iobOut),
    .iobus_pi_req        (piReq),
    .sw_feed             (swFeed),
    .frame_valid         (frameValid),
    .frame               (frameOut),
    .frame_ready         (frameReady)
  );

  // Free-running clock; all checks sample 1ns after the rising edge.
  always #5 clk = ~clk;

  // Watchdog so a stuck design can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d passed=%0d", checksTotal, checksPassed);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [35:0] observed, input logic [35:0] expected);
    checksTotal++;
    assert (observed === expected) begin
      checksPassed++;
    end else begin
      $error("[TB] FAIL %s observed=%0o expected=%0o", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cClr, input logic cSet, input logic dClr,
                               input logic dSet, input logic [35:0] data);
    conoClear  = cClr;
    conoSet    = cSet;
    dataoClear = dClr;
    dataoSet   = dSet;
    iobIn      = data;
    tick();
    conoClear  = 1'b0;
    conoSet    = 1'b0;
    dataoClear = 1'b0;
    dataoSet   = 1'b0;
  endtask

  task automatic coniRead(output logic [35:0] v);
    fmStatus = 1'b1;
    #1;
    v = iobOut;
    fmStatus = 1'b0;
    #1;
  endtask

  function automatic logic [35:0] expConi();
    return 36'({mBinary, mBusy, mDone, mPia});
  endfunction

  function automatic logic [35:0] expPi();
    if (mDone && mPia != 3'd0) return 36'(7'b1 << (7 - int'(mPia)));
    return '0;
  endfunction

  function automatic logic [7:0] expFrame(input logic bin, input logic [7:0] d);
    return bin ? {2'b10, d[5:0]} : d;
  endfunction

  // Clear-then-set leaves the flags exactly equal to the written value.
  task automatic conoWrite(input logic [5:0] flags);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, {30'($urandom), flags});
    {mBinary, mBusy, mDone, mPia} = flags;
  endtask

  task automatic runPunch(input string tag, input logic [7:0] data, input int holdCycles);
    logic [7:0]  expect8;
    logic [35:0] v;
    int          lat;
    logic        stable;
    frameReady = (holdCycles == 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, {28'($urandom), data});
    mBusy = 1'b1;
    mDone = 1'b0;
    expect8 = expFrame(mBinary, data);
    lat = 1;
    while (!frameValid && lat < PC + 20) begin
      tick();
      lat++;
    end
    checkOutput({tag, " latency"}, 36'(lat), 36'(PC + 1));
    checkOutput({tag, " frame"}, 36'(frameOut), 36'(expect8));
    if (holdCycles > 0) begin
      stable = 1'b1;
      for (int i = 0; i < holdCycles; i++) begin
        coniRead(v);
        if (!frameValid || frameOut !== expect8 || v !== expConi()) stable = 1'b0;
        tick();
      end
      checkOutput({tag, " held stable busy"}, 36'(stable), 36'(1));
      frameReady = 1'b1;
    end
    tick();
    frameReady = 1'b0;
    mBusy = 1'b0;
    mDone = 1'b1;
    checkOutput({tag, " valid drops"}, 36'(frameValid), 36'(0));
    coniRead(v);
    checkOutput({tag, " coni done"}, v, expConi());
    checkOutput({tag, " pi_req"}, 36'(piReq), expPi());
  endtask

  initial begin
    logic [35:0] v;
    int          frames;
    int          badFeed;
    logic        sawValid;

    // Reset with garbage and every pulse asserted on the bus.
    reset = 1'b1;
    iobIn = {4'($urandom), 32'($urandom)};
    conoSet = 1'b1; dataoSet = 1'b1; swFeed = 1'b1; fmStatus = 1'b1;
    repeat (3) tick();
    reset = 1'b0; conoSet = 1'b0; dataoSet = 1'b0; swFeed = 1'b0;
    #1;
    checkOutput("reset iob_out", 36'(iobOut), 36'(0));
    checkOutput("reset pi_req", 36'(piReq), 36'(0));
    checkOutput("reset frame_valid", 36'(frameValid), 36'(0));
    checkOutput("reset frame", 36'(frameOut), 36'(0));
    fmStatus = 1'b0;
    tick();

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 36'o000000000045);
    {mBinary, mBusy, mDone, mPia} = 6'o45;
    coniRead(v);
    checkOutput("cono set 45", v, 36'o000000000045);

    conoWrite(6'o05);
    runPunch("datao 301", 8'o301, 0);

    conoWrite(6'o45);
    runPunch("binary 177", 8'o177, 0);
    checkOutput("binary frame 277", 36'(frameOut), 36'(8'o277));

    conoWrite(6'o03);
    runPunch("hold 50", 8'h5a, 50);

    // Wrong device code must be ignored on both CONO and CONI.
    ios = 7'o021;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 36'o77);
    fmStatus = 1'b1;
    #1;
    checkOutput("unselected coni", 36'(iobOut), 36'(0));
    fmStatus = 1'b0;
    ios = DEVNO;
    coniRead(v);
    checkOutput("unselected cono", v, expConi());

    conoWrite(6'o20);
    sawValid = 1'b0;
    for (int i = 0; i < PC + 5; i++) begin
      tick();
      if (frameValid) sawValid = 1'b1;
    end
    checkOutput("cono busy no punch", 36'(sawValid), 36'(0));
    coniRead(v);
    checkOutput("cono busy coni", v, expConi());

    conoWrite(6'o05);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 36'o123);
    repeat (3) tick();
    iobReset = 1'b1;
    tick();
    iobReset = 1'b0;
    {mBinary, mBusy, mDone, mPia} = 6'o00;
    coniRead(v);
    checkOutput("iob_reset coni", v, expConi());
    checkOutput("iob_reset pi_req", 36'(piReq), 36'(0));
    frameReady = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < PC + 10; i++) begin
      if (frameValid) sawValid = 1'b1;
      tick();
    end
    checkOutput("iob_reset no frame", 36'(sawValid), 36'(0));

    conoWrite(6'o05);
    swFeed = 1'b1;
    frameReady = 1'b1;
    frames = 0;
    badFeed = 0;
    for (int i = 0; i < 3 * (PC + 2) + 2; i++) begin
      tick();
      if (frameValid) begin
        frames++;
        if (frameOut !== 8'h00) badFeed++;
      end
    end
    swFeed = 1'b0;
    repeat (2 * PC + 5) tick();
    frameReady = 1'b0;
    checkOutput("feed frame count", 36'(frames >= 2), 36'(1));
    checkOutput("feed frames blank", 36'(badFeed), 36'(0));
    coniRead(v);
    checkOutput("feed done stays 0", v, expConi());
    checkOutput("feed pi_req", 36'(piReq), 36'(0));

    for (int n = 0; n < 16; n++) begin
      logic [5:0] flags;
      flags = {1'($urandom_range(0, 1)), 2'b00, 3'($urandom_range(0, 7))};
      conoWrite(flags);
      coniRead(v);
      checkOutput("rand coni", v, expConi());
      runPunch("rand punch", 8'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
